// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: merges load-use, mul/div, redirect,
// trap and memory-busy hazards into per-stage stall/flush controls, plus a stall counter.
module pipe_hazard_ctrl #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] id_rs1_idx_i,
   input  logic [REG_AW-1:0] id_rs2_idx_i,
   input  logic              id_rs1_used_i,
   input  logic              id_rs2_used_i,
   input  logic              ex_is_load_i,
   input  logic [REG_AW-1:0] ex_rd_idx_i,
   input  logic              ex_busy_i,
   input  logic              ex_redirect_i,
   input  logic              trap_valid_i,
   input  logic              imem_busy_i,
   input  logic              dmem_busy_i,
   output logic              stall_pc_o,
   output logic              stall_if_id_o,
   output logic              stall_id_ex_o,
   output logic              stall_ex_mem_o,
   output logic              stall_mem_wb_o,
   output logic              flush_if_id_o,
   output logic              flush_id_ex_o,
   output logic              flush_ex_mem_o,
   output logic              flush_mem_wb_o,
   output logic              trap_redirect_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   typedef enum logic [1:0] {RUN, TRAP_PEND, REDIR_PEND} state_t;

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] stall_cnt;
   logic             load_use;
   logic             trap_fire;

   assign load_use = ex_is_load_i && (ex_rd_idx_i != '0) &&
                     ((id_rs1_used_i && (id_rs1_idx_i == ex_rd_idx_i)) ||
                      (id_rs2_used_i && (id_rs2_idx_i == ex_rd_idx_i)));

   // A trap can only commit once the data access in MEM has drained.
   assign trap_fire = (trap_valid_i || (state == TRAP_PEND)) && !dmem_busy_i;

   assign stall_cnt_o = stall_cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= RUN;
         stall_cnt <= '0;
      end else begin
         state <= state_next;
         if (stall_pc_o) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
      end
   end

   always_comb begin
      stall_pc_o      = 1'b0;
      stall_if_id_o   = 1'b0;
      stall_id_ex_o   = 1'b0;
      stall_ex_mem_o  = 1'b0;
      stall_mem_wb_o  = 1'b0;
      flush_if_id_o   = 1'b0;
      flush_id_ex_o   = 1'b0;
      flush_ex_mem_o  = 1'b0;
      flush_mem_wb_o  = 1'b0;
      trap_redirect_o = 1'b0;
      state_next      = state;

      if (!rst) begin
         flush_if_id_o  = 1'b1;
         flush_id_ex_o  = 1'b1;
         flush_ex_mem_o = 1'b1;
         flush_mem_wb_o = 1'b1;
         state_next     = RUN;
      end else if (trap_fire) begin
         flush_if_id_o   = 1'b1;
         flush_id_ex_o   = 1'b1;
         flush_ex_mem_o  = 1'b1;
         trap_redirect_o = 1'b1;
         state_next      = RUN;
      end else if (dmem_busy_i) begin
         stall_pc_o     = 1'b1;
         stall_if_id_o  = 1'b1;
         stall_id_ex_o  = 1'b1;
         stall_ex_mem_o = 1'b1;
         flush_mem_wb_o = 1'b1;
         if (trap_valid_i || (state == TRAP_PEND)) begin
            state_next = TRAP_PEND;
         end
      end else if (ex_busy_i) begin
         stall_pc_o     = 1'b1;
         stall_if_id_o  = 1'b1;
         stall_id_ex_o  = 1'b1;
         flush_ex_mem_o = 1'b1;
      end else if (ex_redirect_i) begin
         flush_if_id_o = 1'b1;
         flush_id_ex_o = 1'b1;
         if (imem_busy_i || (state == REDIR_PEND)) begin
            state_next = REDIR_PEND;
         end else begin
            state_next = RUN;
         end
      end else if ((state == REDIR_PEND) && imem_busy_i) begin
         // The outstanding fetch belongs to the old path; keep discarding it.
         flush_if_id_o = 1'b1;
      end else begin
         state_next = RUN;
         if (load_use) begin
            stall_pc_o    = 1'b1;
            stall_if_id_o = 1'b1;
            flush_id_ex_o = 1'b1;
         end else if (imem_busy_i) begin
            stall_pc_o    = 1'b1;
            flush_if_id_o = 1'b1;
         end
      end
   end

endmodule
